// File: rtl/cpu_clk_ctrl_pkg.sv
// rtl/cpu_clk_ctrl_pkg.sv - shared state encoding, mode constants and width helper for cpu_clk_ctrl
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_HALT  = 2'd3
  } ctrlState_t;

  localparam logic [1:0] MODE_STEP = 2'd0;
  localparam logic [1:0] MODE_SLOW = 2'd1;
  localparam logic [1:0] MODE_FAST = 2'd2;
  localparam logic [1:0] MODE_FULL = 2'd3;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_sync_debounce.sv
// rtl/cpu_clk_ctrl_btn_sync_debounce.sv - two-flop sync, debounce and press pulse for an active-low button
module btn_sync_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rstN,
  input  logic btnRaw,
  output logic level,
  output logic press
);

  localparam int CNT_W = cntWidth(DEB_CYCLES);

  logic [1:0]       syncQ;
  logic [CNT_W-1:0] stableCnt;

  // Released (high) is the rest level, so reset never looks like a press.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncQ     <= 2'b11;
      stableCnt <= '0;
      level     <= 1'b1;
      press     <= 1'b0;
    end else begin
      syncQ <= {syncQ[0], btnRaw};
      press <= 1'b0;
      if (syncQ[1] == level) begin
        stableCnt <= '0;
      end else if (stableCnt == CNT_W'(DEB_CYCLES - 1)) begin
        stableCnt <= '0;
        level     <= syncQ[1];
        press     <= level;
      end else begin
        stableCnt <= stableCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - CPU clock-enable controller with POR, debounce, burst step; CPU_CLK_CTRL_BREAKPOINT_EN adds PC breakpoint
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_SLOW   = 6000000,
  parameter int DIV_FAST   = 600000,
  parameter int DIV_W      = 24,
  parameter int DEB_CYCLES = 240000,
  parameter int POR_CYCLES = 65535,
  parameter int STEP_W     = 3
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
  ,
  parameter int ADDR_W     = 12
`endif
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              clkBtn,
  input  logic              extRstBtn,
  input  logic [1:0]        modeSel,
  input  logic [STEP_W-1:0] stepCount,
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] pcAddr,
  input  logic [ADDR_W-1:0] bpAddr,
  input  logic              bpValid,
`endif
  output logic              cpuClkEn,
  output logic              cpuRstN,
  output logic              porDone,
  output logic              stepBusy,
  output logic              halted
);

  localparam int POR_W = cntWidth(POR_CYCLES);

  logic [1:0]        modeMeta;
  logic [1:0]        modeSync;
  logic [1:0]        modePrev;
  logic              modeChg;
  logic [POR_W-1:0]  porCnt;
  logic              clkLevel;
  logic              clkPress;
  logic              extLevel;
  logic              extPress;
  logic              stepPress;
  logic [DIV_W-1:0]  divCnt;
  logic [DIV_W-1:0]  divMax;
  logic              divMode;
  logic              divDue;
  logic              pulseDue;
  logic              bpHit;
  logic [STEP_W-1:0] rem;
  ctrlState_t        state;
  ctrlState_t        nextState;

  btn_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) uClkBtn (
    .clk    (clk),
    .rstN   (rstN),
    .btnRaw (clkBtn),
    .level  (clkLevel),
    .press  (clkPress)
  );

  btn_sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) uExtRstBtn (
    .clk    (clk),
    .rstN   (rstN),
    .btnRaw (extRstBtn),
    .level  (extLevel),
    .press  (extPress)
  );

  assign stepPress = clkPress & ~clkLevel;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      modeMeta <= MODE_STEP;
      modeSync <= MODE_STEP;
      modePrev <= MODE_STEP;
    end else begin
      modeMeta <= modeSel;
      modeSync <= modeMeta;
      modePrev <= modeSync;
    end
  end

  assign modeChg = (modeSync != modePrev);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      porCnt  <= '0;
      porDone <= 1'b0;
    end else if (!porDone) begin
      if (porCnt == POR_W'(POR_CYCLES - 1)) begin
        porDone <= 1'b1;
      end else begin
        porCnt <= porCnt + POR_W'(1);
      end
    end
  end

  // The press pulse coincides with the debounced low level, so either holds the CPU in reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cpuRstN <= 1'b0;
    end else begin
      cpuRstN <= porDone & extLevel & ~extPress;
    end
  end

  assign divMode  = (modeSync == MODE_SLOW) || (modeSync == MODE_FAST);
  assign divMax   = (modeSync == MODE_SLOW) ? DIV_W'(DIV_SLOW - 1) : DIV_W'(DIV_FAST - 1);
  assign divDue   = divMode && (divCnt == divMax);
  assign pulseDue = (modeSync == MODE_FULL) || divDue;

`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
  assign bpHit = bpValid && (pcAddr == bpAddr);
`else
  assign bpHit = 1'b0;
`endif

  // Divider runs in any divided mode so the first pulse lands DIV cycles after the mode settles.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      divCnt <= '0;
    end else if (!cpuRstN || modeChg || !divMode || divDue) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rem <= '0;
    end else if ((state == ST_IDLE) && (nextState == ST_BURST)) begin
      rem <= stepCount;
    end else if ((state == ST_BURST) && (rem != '0)) begin
      rem <= rem - STEP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (!cpuRstN || modeChg) begin
      nextState = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (modeSync != MODE_STEP) begin
            nextState = ST_RUN;
          end else if (stepPress) begin
            nextState = ST_BURST;
          end
        end
        ST_RUN: begin
          if (modeSync == MODE_STEP) begin
            nextState = ST_IDLE;
          end else if (pulseDue && bpHit) begin
            nextState = ST_HALT;
          end
        end
        ST_BURST: begin
          if (rem == '0) begin
            nextState = ST_IDLE;
          end
        end
        ST_HALT: begin
          if (stepPress) begin
            nextState = ST_RUN;
          end
        end
        default: nextState = ST_IDLE;
      endcase
    end
  end

  // In HALT the press itself is the single released pulse; the breakpoint compare is bypassed.
  always_comb begin
    cpuClkEn = 1'b0;
    if (cpuRstN && !modeChg) begin
      case (state)
        ST_RUN:   cpuClkEn = pulseDue && !bpHit;
        ST_BURST: cpuClkEn = 1'b1;
        ST_HALT:  cpuClkEn = stepPress;
        default:  cpuClkEn = 1'b0;
      endcase
    end
  end

  assign stepBusy = (state == ST_BURST);

`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
